// File: rtl/sp_pack_ctrl_if.sv
// Handshake bundle for the beat packer: upstream beats in, assembled words out.
// master = the side that feeds beats and consumes words; slave = the packer.
interface sp_pack_ctrl_if #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 2
);
    localparam int unsigned W  = M * N;
    localparam int unsigned CW = $clog2(M + 1);

    logic          in_valid;
    logic [N-1:0]  in_data;
    logic          in_ready;
    logic          flush;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_partial;
    logic          out_ready;
    logic [CW-1:0] fill_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, out_partial, fill_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, out_partial, fill_cnt
    );
endinterface

// File: rtl/sp_pack_ctrl.sv
// Packs M beats of N bits into one M*N-bit word, first beat in the MSBs.
// A flush closes a partial word early, zero-padding the unused low beats.
module sp_pack_ctrl #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 2
) (
    input  logic           clk,
    input  logic           reset,
    sp_pack_ctrl_if.slave  bus
);
    localparam int unsigned W  = M * N;
    localparam int unsigned CW = $clog2(M + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          partial_q, partial_d;

    logic          in_ready;
    logic          accept;
    logic          out_valid;
    logic [W-1:0]  acc_data;
    logic [CW-1:0] acc_cnt;

    // Left-justify a word holding c beats by pushing zero beats in behind it.
    function automatic logic [W-1:0] pad_word(input logic [W-1:0] d, input logic [CW-1:0] c);
        return d << (N * (M - 32'(c)));
    endfunction

    // Backpressure only while a finished word waits; reset forces not-ready.
    assign in_ready  = reset && ((state_q != FULL) || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign out_valid = (state_q == FULL);

    assign acc_data = {data_q[W-N-1:0], bus.in_data};
    assign acc_cnt  = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            cnt_q     <= '0;
            partial_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;

        unique case (state_q)
            IDLE: begin
                // Flush with nothing held is a no-op, even alongside a beat.
                if (accept) begin
                    data_d  = W'(bus.in_data);
                    cnt_d   = CW'(1);
                    state_d = FILL;
                end
            end

            FILL: begin
                if (accept) begin
                    if (acc_cnt == CW'(M)) begin
                        data_d    = acc_data;
                        cnt_d     = '0;
                        partial_d = 1'b0;
                        state_d   = FULL;
                    end else if (bus.flush) begin
                        data_d    = pad_word(acc_data, acc_cnt);
                        cnt_d     = '0;
                        partial_d = 1'b1;
                        state_d   = FULL;
                    end else begin
                        data_d = acc_data;
                        cnt_d  = acc_cnt;
                    end
                end else if (bus.flush) begin
                    data_d    = pad_word(data_q, cnt_q);
                    cnt_d     = '0;
                    partial_d = 1'b1;
                    state_d   = FULL;
                end
            end

            FULL: begin
                // Consume and optionally start the next word in the same cycle.
                if (bus.out_ready) begin
                    partial_d = 1'b0;
                    if (accept) begin
                        data_d  = W'(bus.in_data);
                        cnt_d   = CW'(1);
                        state_d = FILL;
                    end else begin
                        data_d  = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                data_d    = '0;
                cnt_d     = '0;
                partial_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_valid ? data_q : '0;
    assign bus.out_partial = partial_q;
    assign bus.fill_cnt    = cnt_q;

    // A word left waiting must not change underneath the consumer.
    a_hold_stable: assert property (@(posedge clk) disable iff (!reset)
        (out_valid && !bus.out_ready) |=> (out_valid && $stable(data_q) && $stable(partial_q)));

    a_cnt_range: assert property (@(posedge clk) disable iff (!reset)
        (32'(cnt_q) < M));

endmodule

// File: tb/tb_sp_pack_ctrl.sv
// Directed and randomized bench for sp_pack_ctrl (N=4, M=2) against a beat-queue model.
module tb_sp_pack_ctrl;
    localparam int unsigned N = 4;
    localparam int unsigned M = 2;
    localparam int unsigned W = M * N;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    sp_pack_ctrl_if #(.N(N), .M(M)) bus ();

    sp_pack_ctrl #(.N(N), .M(M)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: beats of the unfinished word in arrival order, plus the presented word.
    int unsigned  held[$];
    bit           mdl_full;
    bit           mdl_part;
    logic [W-1:0] mdl_word;
    bit           mdl_known;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_beats(input int unsigned b[$]);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(M); i++) begin
            w = w << N;
            if (i < b.size()) w = w | W'(b[i] & ((1 << N) - 1));
        end
        return w;
    endfunction

    // One clock: drive at negedge, check against the model, advance the model, settle after posedge.
    task automatic cycle(input bit rst, input bit iv, input int unsigned id, input bit fl, input bit ordy);
        bit exp_ready;
        bit acc;
        bit was_empty;
        @(negedge clk);
        rst_n         = rst;
        bus.in_valid  = iv;
        bus.in_data   = N'(id);
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        exp_ready = rst && (!mdl_full || ordy);
        chk_eq("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        if (mdl_known) begin
            chk_eq("out_valid",   32'(bus.out_valid),   32'(mdl_full));
            chk_eq("out_data",    32'(bus.out_data),    mdl_full ? 32'(mdl_word) : 32'd0);
            chk_eq("out_partial", 32'(bus.out_partial), 32'(mdl_full && mdl_part));
            chk_eq("fill_cnt",    32'(bus.fill_cnt),    32'(held.size()));
        end
        acc = iv && exp_ready;
        if (!rst) begin
            held.delete();
            mdl_full  = 1'b0;
            mdl_part  = 1'b0;
            mdl_word  = '0;
            mdl_known = 1'b1;
        end else if (mdl_full) begin
            if (ordy) begin
                mdl_full = 1'b0;
                mdl_part = 1'b0;
                if (acc) held.push_back(id & ((1 << N) - 1));
            end
        end else begin
            was_empty = (held.size() == 0);
            if (acc) held.push_back(id & ((1 << N) - 1));
            if (held.size() == M) begin
                mdl_word = pack_beats(held);
                mdl_part = 1'b0;
                mdl_full = 1'b1;
                held.delete();
            end else if (fl && !was_empty) begin
                mdl_word = pack_beats(held);
                mdl_part = 1'b1;
                mdl_full = 1'b1;
                held.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        mdl_known     = 1'b0;
        mdl_full      = 1'b0;
        mdl_part      = 1'b0;
        mdl_word      = '0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset for two cycles, then release.
        cycle(0, 1, 4'h3, 1, 1);
        cycle(0, 1, 4'h3, 1, 1);
        chk_eq("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk_eq("rst_out_data", 32'(bus.out_data), 32'h00);
        chk_eq("rst_fill_cnt", 32'(bus.fill_cnt), 32'd0);
        cycle(1, 0, 0, 0, 0);
        chk_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Full word held under backpressure; flush in FULL ignored.
        cycle(1, 1, 4'hA, 0, 0);
        cycle(1, 1, 4'h5, 0, 0);
        chk_eq("a5_valid", 32'(bus.out_valid), 32'd1);
        chk_eq("a5_data", 32'(bus.out_data), 32'hA5);
        chk_eq("a5_partial", 32'(bus.out_partial), 32'd0);
        chk_eq("a5_in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 4'hF, 1, 0);
            chk_eq("a5_hold_data", 32'(bus.out_data), 32'hA5);
            chk_eq("a5_hold_valid", 32'(bus.out_valid), 32'd1);
        end

        // Zero-bubble: consume and load the next first beat together.
        cycle(1, 1, 4'h3, 0, 1);
        chk_eq("zb_valid", 32'(bus.out_valid), 32'd0);
        chk_eq("zb_fill", 32'(bus.fill_cnt), 32'd1);
        cycle(1, 1, 4'hC, 0, 0);
        chk_eq("zb_data", 32'(bus.out_data), 32'h3C);
        cycle(1, 0, 0, 0, 1);

        // Flush alone pads with zeros.
        cycle(1, 1, 4'h7, 0, 0);
        cycle(1, 0, 0, 1, 0);
        chk_eq("fl_valid", 32'(bus.out_valid), 32'd1);
        chk_eq("fl_data", 32'(bus.out_data), 32'h70);
        chk_eq("fl_partial", 32'(bus.out_partial), 32'd1);
        chk_eq("fl_fill", 32'(bus.fill_cnt), 32'd0);
        cycle(1, 0, 0, 0, 1);

        // Flush with the completing beat yields a normal word.
        cycle(1, 1, 4'h7, 0, 0);
        cycle(1, 1, 4'h2, 1, 0);
        chk_eq("flb_data", 32'(bus.out_data), 32'h72);
        chk_eq("flb_partial", 32'(bus.out_partial), 32'd0);
        cycle(1, 0, 0, 0, 1);

        // Reset mid-fill discards the held beat; flush in IDLE makes nothing.
        cycle(1, 1, 4'h9, 0, 0);
        chk_eq("mr_fill", 32'(bus.fill_cnt), 32'd1);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 1, 4'h1, 0, 0);
        cycle(1, 1, 4'h2, 0, 0);
        chk_eq("mr_data", 32'(bus.out_data), 32'h12);
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 1, 0);
        chk_eq("idle_fl_valid", 32'(bus.out_valid), 32'd0);
        chk_eq("idle_fl_fill", 32'(bus.fill_cnt), 32'd0);
        cycle(1, 0, 0, 0, 0);
        chk_eq("idle_fl_valid2", 32'(bus.out_valid), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99, 0) >= 2),
                  ($urandom_range(99, 0) < 60),
                  $urandom_range((1 << N) - 1, 0),
                  ($urandom_range(99, 0) < 15),
                  ($urandom_range(99, 0) < 50));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
